core_sequencer: RTL

Multi-cycle control FSM for the RV32I core. It owns the program counter and fetches instructions over a ready/req instruction-memory handshake. It presents each instruction to the instruction decoder, then steps the execute, data-memory and write-back phases using the decoder's class flags (is_load/is_store/is_branch/is_jump/is_alu). It also detects bus timeouts, illegal opcodes and misaligned control transfers, and halts on them.

---
 rtl/core_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the RV32I core.
// Owns the PC, fetches over a req/ready handshake, steps EXEC/MEM/WB using
// decoder class flags, and halts (sticky) on bus timeout, illegal opcode or
// misaligned control transfer.
module core_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_branch,
  input  logic        is_jump,
  input  logic        is_alu,
  input  logic        branch_taken,
  input  logic [31:0] jump_target,
  output logic        alu_en,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic        halted,
  output logic [1:0]  err
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [1:0]  ERR_NONE      = 2'd0;
  localparam logic [1:0]  ERR_TIMEOUT   = 2'd1;
  localparam logic [1:0]  ERR_ILLEGAL   = 2'd2;
  localparam logic [1:0]  ERR_MISALIGN  = 2'd3;
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(MEM_TIMEOUT);

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  w_next_err;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instret;
  logic [31:0] r_tgt;
  logic [15:0] r_wait_cnt;
  logic        r_tk;
  logic        r_wr;
  logic        r_dmem_we;
  logic        r_halted;
  logic [1:0]  r_err;
  logic        w_take;
  logic        w_writes;
  logic        w_any_class;
  logic        w_wait_expired;

  // Class decode of the flags presented in EXEC
  assign w_take         = is_jump | (is_branch & branch_taken);
  assign w_writes       = is_load | is_alu | is_jump;
  assign w_any_class    = is_load | is_store | is_branch | is_jump | is_alu;
  assign w_wait_expired = (r_wait_cnt == TIMEOUT_LIMIT);

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign instr     = r_instr;
  assign instret   = r_instret;
  assign dmem_we   = r_dmem_we;
  assign halted    = r_halted;
  assign err       = r_err;

  // State register; reset always restarts at FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, halt cause and state-decoded strobes (all dropped during reset)
  always_comb begin
    w_next_state = r_state;
    w_next_err   = r_err;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    alu_en       = 1'b0;
    rf_we        = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          w_next_state = S_DECODE;
        end else if (w_wait_expired) begin
          w_next_state = S_HALT;
          w_next_err   = ERR_TIMEOUT;
        end
      end
      S_DECODE: begin
        w_next_state = S_EXEC;
      end
      S_EXEC: begin
        alu_en = 1'b1;
        if (!w_any_class) begin
          w_next_state = S_HALT;
          w_next_err   = ERR_ILLEGAL;
        end else if (w_take && (jump_target[1:0] != 2'b00)) begin
          w_next_state = S_HALT;
          w_next_err   = ERR_MISALIGN;
        end else if (is_load || is_store) begin
          w_next_state = S_MEM;
        end else begin
          w_next_state = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          w_next_state = S_WB;
        end else if (w_wait_expired) begin
          w_next_state = S_HALT;
          w_next_err   = ERR_TIMEOUT;
        end
      end
      S_WB: begin
        rf_we        = r_wr;
        w_next_state = S_FETCH;
      end
      S_HALT: begin
        w_next_state = S_HALT;
      end
      default: begin
        w_next_state = S_FETCH;
      end
    endcase
    if (reset) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      alu_en   = 1'b0;
      rf_we    = 1'b0;
    end
  end

  // Architectural state: PC, instruction latch, retire count, EXEC latches, wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_instr    <= 32'd0;
      r_instret  <= 32'd0;
      r_tgt      <= 32'd0;
      r_tk       <= 1'b0;
      r_wr       <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_halted   <= 1'b0;
      r_err      <= ERR_NONE;
      r_wait_cnt <= 16'd0;
    end else begin
      r_err <= w_next_err;
      if (w_next_state == S_HALT) begin
        r_halted <= 1'b1;
      end
      case (r_state)
        S_FETCH: begin
          if (imem_ready) begin
            r_instr <= imem_rdata;
          end else if (!w_wait_expired) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        S_EXEC: begin
          r_tk       <= w_take;
          r_tgt      <= jump_target;
          r_wr       <= w_writes;
          r_dmem_we  <= is_store;
          r_wait_cnt <= 16'd0;
        end
        S_MEM: begin
          if (!dmem_ready && !w_wait_expired) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        S_WB: begin
          r_pc       <= r_tk ? r_tgt : (r_pc + 32'd4);
          r_instret  <= r_instret + 32'd1;
          r_wait_cnt <= 16'd0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
